// File: rtl/div8_pkg.sv
// div8_pkg: shared widths, constants, state encoding and small helpers
// for the sequential restoring divider.
package div8_pkg;

  // Operand and result width; the datapath is written for 8 bits only.
  localparam int DIV_W = 8;

  // Number of restoring iterations, one quotient bit per clock.
  localparam int ITER_COUNT = DIV_W;

  // Width of the iteration counter that runs ITER_COUNT-1 down to 0.
  localparam int CNT_W = $clog2(ITER_COUNT);

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 8'hFF;

  // Most negative two's-complement value, used to spot -128 / -1.
  localparam logic [DIV_W-1:0] SIGNED_MIN = {1'b1, {(DIV_W-1){1'b0}}};

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negation at operand width.
  function automatic logic [DIV_W-1:0] negate(input logic [DIV_W-1:0] value);
    return ~value + DIV_W'(1);
  endfunction

  // Magnitude of a value that is optionally treated as signed.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] value,
                                                 input logic             is_signed);
    return (is_signed && value[DIV_W-1]) ? negate(value) : value;
  endfunction

endpackage

// File: rtl/div8_step.sv
// div8_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and performs a
// 9-bit trial subtraction (add of the divisor's two's complement); the
// sign of the trial result decides the quotient bit and whether the
// subtraction is kept or the shifted remainder is restored.
module div8_step
  import div8_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic [DIV_W-1:0] quo_in,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W:0]   rem_out,
  output logic [DIV_W-1:0] quo_out
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // The partial remainder is always below the divisor, so only its low
  // DIV_W bits take part in the shift; the top bit is carried for width.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_in[DIV_W];

  // Trial subtraction and restore decision for a single quotient bit.
  always_comb begin
    shifted = {rem_in[DIV_W-1:0], quo_in[DIV_W-1]};
    trial   = shifted + {1'b1, ~dvs} + (DIV_W+1)'(1);
    if (!trial[DIV_W]) begin
      rem_out = trial;
      quo_out = {quo_in[DIV_W-2:0], 1'b1};
    end else begin
      rem_out = shifted;
      quo_out = {quo_in[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div8_seq.sv
// div8_seq: sequential 8-bit restoring divider with start/done handshake.
// IDLE accepts a request, CALC retires one quotient bit per clock for
// eight clocks, DONE finalises the results, which are published together
// with a one-cycle done pulse as the controller returns to IDLE.
// Optional feature macro: DIV8_SIGNED_EN enables two's-complement
// operation via signed_op (abs at capture, sign correction, overflow).
module div8_seq
  import div8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state;
  logic [CNT_W-1:0] iter_cnt;
  logic [DIV_W:0]   rem_r;
  logic [DIV_W-1:0] quo_r;
  logic [DIV_W-1:0] dvs_mag;
  logic             dz_pend;

  logic [DIV_W:0]   rem_next;
  logic [DIV_W-1:0] quo_next;

  logic [DIV_W-1:0] dividend_mag;
  logic [DIV_W-1:0] divisor_mag;
  logic [DIV_W-1:0] final_quo;
  logic [DIV_W-1:0] final_rem;

  logic             accept;
  logic             divisor_zero;

  assign accept       = (state == IDLE) && start;
  assign divisor_zero = (divisor == '0);

  div8_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvs     (dvs_mag),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

`ifdef DIV8_SIGNED_EN

  logic neg_quo;
  logic neg_rem;
  logic ovf_pend;

  assign dividend_mag = magnitude(dividend, signed_op);
  assign divisor_mag  = magnitude(divisor, signed_op);

  // Divide-by-zero results bypass sign correction, so the negate flags
  // are only set for a real division.
  assign final_quo = neg_quo ? negate(quo_r) : quo_r;
  assign final_rem = neg_rem ? negate(rem_r[DIV_W-1:0]) : rem_r[DIV_W-1:0];

  // Capture the sign bookkeeping with the operands and publish overflow
  // together with the other results.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        neg_quo  <= signed_op && !divisor_zero &&
                    (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
        neg_rem  <= signed_op && !divisor_zero && dividend[DIV_W-1];
        ovf_pend <= signed_op && (dividend == SIGNED_MIN) && (divisor == '1);
      end
      if (state == DONE) begin
        overflow <= ovf_pend;
      end
    end
  end

`else

  // Unsigned-only build: signed_op has no effect and no sign logic exists.
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign final_quo    = quo_r;
  assign final_rem    = rem_r[DIV_W-1:0];
  assign overflow     = 1'b0;

`endif

  // Controller, iteration datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_mag     <= '0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dz_pend <= divisor_zero;
            dvs_mag <= divisor_mag;
            if (divisor_zero) begin
              quo_r <= DIV0_QUOTIENT;
              rem_r <= {1'b0, dividend};
              state <= DONE;
            end else begin
              quo_r    <= dividend_mag;
              rem_r    <= '0;
              iter_cnt <= CNT_W'(ITER_COUNT - 1);
              busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end

        CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          if (iter_cnt == '0) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            iter_cnt <= iter_cnt - CNT_W'(1);
          end
        end

        DONE: begin
          done        <= 1'b1;
          quotient    <= final_quo;
          remainder   <= final_rem;
          div_by_zero <= dz_pend;
          state       <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: scoreboard bench for div8_seq with directed vectors.
// Expected results are queued when a request is issued; a monitor pops
// and compares whenever done is seen. Signed vectors use the expectations
// matching whether DIV8_SIGNED_EN is defined.
module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       signed_op;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } result_t;

  result_t exp_queue[$];
  int      checks = 0;
  int      errors = 0;

  div8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // One comparison: counts it, reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Monitor: each done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    result_t e;
    if (done === 1'b1) begin
      if (exp_queue.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_queue.pop_front();
        checkOutput("quotient", 32'(quotient), 32'(e.q));
        checkOutput("remainder", 32'(remainder), 32'(e.r));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        checkOutput("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  // Issue one request, queue its expectation and check handshake timing.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic [7:0] eq,
                               input logic [7:0] er, input logic edz,
                               input logic eov);
    result_t e;
    int      lat_exp;
    int      lat;
    bit      busy_ok;
    lat_exp = (b == 8'd0) ? 1 : 9;
    lat     = 0;
    busy_ok = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    exp_queue.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (b == 8'd0) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (i <= 7 && busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(lat_exp));
    checkOutput("busy_window", 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("hold_quotient", 32'(quotient), 32'(eq));
    checkOutput("hold_remainder", 32'(remainder), 32'(er));
  endtask

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    signed_op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quotient", 32'(quotient), 32'd0);
    checkOutput("rst_remainder", 32'(remainder), 32'd0);
    checkOutput("rst_dz", 32'(div_by_zero), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned vectors, including boundaries and divide by zero.
    applyStimulus(8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, 1'b0);
    applyStimulus(8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0);
    applyStimulus(8'd5,   8'd9,   1'b0, 8'd0,   8'd5,   1'b0, 1'b0);
    applyStimulus(8'd13,  8'd0,   1'b0, 8'hFF,  8'd13,  1'b1, 1'b0);
    applyStimulus(8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0);
    applyStimulus(8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 1'b0);

    // Signed-request vectors.
`ifdef DIV8_SIGNED_EN
    applyStimulus(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    applyStimulus(8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0);
    applyStimulus(8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0, 1'b0);
`else
    applyStimulus(8'h9C, 8'h07, 1'b1, 8'h16, 8'h02, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0);
    applyStimulus(8'h64, 8'hF9, 1'b1, 8'h00, 8'h64, 1'b0, 1'b0);
    applyStimulus(8'h9C, 8'hF9, 1'b1, 8'h00, 8'h9C, 1'b0, 1'b0);
`endif
    applyStimulus(8'h9C, 8'h07, 1'b0, 8'h16, 8'h02, 1'b0, 1'b0);
    applyStimulus(8'h9C, 8'h00, 1'b1, 8'hFF, 8'h9C, 1'b1, 1'b0);

    // Start held high during edges t+2..t+8 must be ignored.
    begin
      result_t e;
      int      lat;
      e.q = 8'd14; e.r = 8'd2; e.dz = 1'b0; e.ov = 1'b0;
      lat = 0;
      @(negedge clk);
      dividend = 8'd100; divisor = 8'd7; signed_op = 1'b0; start = 1'b1;
      exp_queue.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1; dividend = 8'd200; divisor = 8'd3;
      repeat (7) @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
          lat = i;
          break;
        end
      end
      checkOutput("ignore_start_latency", 32'(lat), 32'd1);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("ignore_start_idle", 32'(busy), 32'd0);
    end

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_quotient", 32'(quotient), 32'd0);
    checkOutput("midrst_remainder", 32'(remainder), 32'd0);
    checkOutput("midrst_dz", 32'(div_by_zero), 32'd0);
    checkOutput("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    applyStimulus(8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", 32'(exp_queue.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
